// File: rtl/fun_pkg.sv
// Shared encodings, FSM states and sizing functions for the fun_root_mul arithmetic unit.
package fun_pkg;

  localparam logic MODE_CBRT = 1'b0;
  localparam logic MODE_SQRT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROOT = 2'd1,
    MUL  = 2'd2
  } state_e;

  // Number of root bits (and recurrence steps) for a W-bit radicand.
  function automatic int root_digits(input int w, input logic mode);
    if (mode == MODE_SQRT) begin
      return (w + 1) / 2;
    end else begin
      return (w + 2) / 3;
    end
  endfunction

  function automatic int res_width(input int w);
    return w + (w + 1) / 2;
  endfunction

endpackage

// File: rtl/fun_root.sv
// Restoring digit-recurrence integer root: cube root or square root, one root bit per step, MSB first.
module fun_root
  import fun_pkg::*;
#(
  parameter int W  = 8,
  parameter int RW = (W + 1) / 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_init,
  input  logic          i_step,
  input  logic          i_mode,
  input  logic [W-1:0]  i_b,
  output logic [RW-1:0] o_root
);

  localparam int LW = W + 2 * RW + 4;
  localparam int SW = $clog2(3 * RW + 1);
  localparam int NC = root_digits(W, MODE_CBRT);
  localparam int NS = root_digits(W, MODE_SQRT);
  localparam logic [LW-1:0] ONE = {{(LW-1){1'b0}}, 1'b1};

  logic [RW-1:0] r_y;
  logic [W-1:0]  r_rem;
  logic [SW-1:0] r_s;
  logic          r_mode;

  logic [LW-1:0] w_y2;
  logic [LW-1:0] w_t;
  logic [LW-1:0] w_rem;
  logic [W-1:0]  w_diff;
  logic          w_fit;

  // Trial term for this digit and the restoring compare/subtract, all in a width wide enough for W=32.
  always_comb begin
    w_y2 = {{(LW-RW){1'b0}}, r_y} << 1;
    if (r_mode == MODE_SQRT) begin
      w_t = (w_y2 << 1) + ONE;
    end else begin
      w_t = (w_y2 + (w_y2 << 1)) * (w_y2 + ONE) + ONE;
    end
    w_rem  = {{(LW-W){1'b0}}, r_rem};
    w_fit  = (w_rem >> r_s) >= w_t;
    w_diff = W'(w_rem - (w_t << r_s));
  end

  // Recurrence state: partial root, remainder and current digit shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y    <= '0;
      r_rem  <= '0;
      r_s    <= '0;
      r_mode <= MODE_CBRT;
    end else if (i_init) begin
      r_y    <= '0;
      r_rem  <= i_b;
      r_mode <= i_mode;
      r_s    <= (i_mode == MODE_SQRT) ? SW'(2 * (NS - 1)) : SW'(3 * (NC - 1));
    end else if (i_step) begin
      if (w_fit) begin
        r_y   <= w_y2[RW-1:0] | {{(RW-1){1'b0}}, 1'b1};
        r_rem <= w_diff;
      end else begin
        r_y   <= w_y2[RW-1:0];
      end
      r_s <= r_s - ((r_mode == MODE_SQRT) ? SW'(2'd2) : SW'(2'd3));
    end
  end

  assign o_root = r_y;

endmodule

// File: rtl/fun_root_mul.sv
// result = a * floor(root(b)) with a start/busy/done handshake; square-root mode is built only with FUN_SQRT_EN.
module fun_root_mul
  import fun_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode_i,
  input  logic [W-1:0]              a_i,
  input  logic [W-1:0]              b_i,
  output logic [res_width(W)-1:0]   result,
  output logic                      busy,
  output logic                      done
);

  localparam int RES_W = res_width(W);
  localparam int RW    = root_digits(W, MODE_SQRT);
  localparam int NC    = root_digits(W, MODE_CBRT);
  localparam int NS    = root_digits(W, MODE_SQRT);
  localparam int CW    = $clog2(RW + 1);

  state_e           r_state, w_state_nxt;
  logic [W-1:0]     r_a;
  logic             r_mode;
  logic [CW-1:0]    r_cnt;
  logic [RES_W-1:0] r_acc, r_result, w_addend, w_acc_nxt;
  logic             r_busy, r_done;
  logic             w_mode_in, w_init, w_step, w_last, w_bit;
  logic [CW-1:0]    w_n;
  logic [RW-1:0]    w_root;

`ifdef FUN_SQRT_EN
  assign w_mode_in = mode_i;
`else
  assign w_mode_in = mode_i & MODE_CBRT;
`endif

  assign w_n    = (r_mode == MODE_SQRT) ? CW'(NS) : CW'(NC);
  assign w_last = (r_cnt == (w_n - CW'(1'b1)));
  assign w_init = (r_state == IDLE) && start;
  assign w_step = (r_state == ROOT);

  fun_root #(.W(W), .RW(RW)) u_root (
    .clk    (clk),
    .rst    (rst),
    .i_init (w_init),
    .i_step (w_step),
    .i_mode (w_mode_in),
    .i_b    (b_i),
    .o_root (w_root)
  );

  // Shift-add multiplier: root bit r_cnt selects a << r_cnt.
  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < RW; i++) begin
      w_bit = (r_cnt == CW'(i)) ? w_root[i] : w_bit;
    end
    w_addend  = {{(RES_W-W){1'b0}}, r_a} << r_cnt;
    w_acc_nxt = w_bit ? (r_acc + w_addend) : r_acc;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = ROOT; else w_state_nxt = IDLE;
      ROOT:    if (w_last) w_state_nxt = MUL;  else w_state_nxt = ROOT;
      MUL:     if (w_last) w_state_nxt = IDLE; else w_state_nxt = MUL;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch, step counter, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_mode   <= MODE_CBRT;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a    <= a_i;
            r_mode <= w_mode_in;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_busy <= 1'b1;
          end
        end
        ROOT: begin
          r_cnt <= w_last ? '0 : (r_cnt + CW'(1'b1));
        end
        MUL: begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_last ? '0 : (r_cnt + CW'(1'b1));
          if (w_last) begin
            r_result <= w_acc_nxt;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_fun_root_mul.sv
// Directed and model-checked bench for fun_root_mul at W=8 and W=12; expectations follow FUN_SQRT_EN.
module tb_fun_root_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, mode_i = 1'b0;
  logic [7:0]  a_i = 8'd0, b_i = 8'd0;
  logic [11:0] result;
  logic        busy, done;

  logic        start12 = 1'b0, mode12 = 1'b0;
  logic [11:0] a12 = 12'd0, b12 = 12'd0;
  logic [17:0] result12;
  logic        busy12, done12;

  int total = 0;
  int bad   = 0;

  fun_root_mul #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_i(mode_i),
    .a_i(a_i), .b_i(b_i), .result(result), .busy(busy), .done(done)
  );

  fun_root_mul #(.W(12)) dut12 (
    .clk(clk), .rst(rst), .start(start12), .mode_i(mode12),
    .a_i(a12), .b_i(b12), .result(result12), .busy(busy12), .done(done12)
  );

  always #5 clk = ~clk;

  function automatic bit eff_mode(input bit m);
`ifdef FUN_SQRT_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  function automatic int ref_root(input int b, input bit m);
    int y = 0;
    if (eff_mode(m)) begin
      while ((y + 1) * (y + 1) <= b) y++;
    end else begin
      while ((y + 1) * (y + 1) * (y + 1) <= b) y++;
    end
    return y;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit m,
                        output int res, output int bcyc, output int dcnt);
    @(negedge clk);
    a_i = a; b_i = b; mode_i = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res = -1; bcyc = 0; dcnt = 0;
    for (int k = 0; k < 100 && dcnt == 0; k++) begin
      if (busy) bcyc++;
      if (done) begin dcnt++; res = int'(result); end
      else @(negedge clk);
    end
    @(negedge clk);
    if (done) dcnt++;
  endtask

  task automatic run_op12(input logic [11:0] a, input logic [11:0] b, input bit m,
                          output int res, output int bcyc, output int dcnt);
    @(negedge clk);
    a12 = a; b12 = b; mode12 = m; start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    res = -1; bcyc = 0; dcnt = 0;
    for (int k = 0; k < 100 && dcnt == 0; k++) begin
      if (busy12) bcyc++;
      if (done12) begin dcnt++; res = int'(result12); end
      else @(negedge clk);
    end
    @(negedge clk);
    if (done12) dcnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (result !== 12'd0) begin bad++; $display("FAIL reset_result got=%0d want=0", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b1;
  endtask

  task automatic test_vectors(input string name, input bit m, input int cnt,
                              input int va[4], input int vb[4], input int ve[4], input int lat);
    int res, bcyc, dcnt;
    for (int i = 0; i < cnt; i++) begin
      run_op(8'(va[i]), 8'(vb[i]), m, res, bcyc, dcnt);
      total++; if (res !== ve[i]) begin bad++; $display("FAIL %s_result[%0d] got=%0d want=%0d", name, i, res, ve[i]); end
      total++; if (bcyc !== lat) begin bad++; $display("FAIL %s_busy_cycles[%0d] got=%0d want=%0d", name, i, bcyc, lat); end
      total++; if (dcnt !== 1) begin bad++; $display("FAIL %s_done_pulses[%0d] got=%0d want=1", name, i, dcnt); end
    end
  endtask

  task automatic test_cbrt();
    test_vectors("cbrt", 1'b0, 3, '{5, 255, 44, 0}, '{27, 200, 255, 0}, '{15, 1275, 264, 0}, 6);
  endtask

  task automatic test_sqrt();
`ifdef FUN_SQRT_EN
    test_vectors("sqrt", 1'b1, 2, '{3, 255, 0, 0}, '{64, 255, 0, 0}, '{24, 3825, 0, 0}, 8);
`else
    test_vectors("sqrt_off", 1'b1, 2, '{3, 255, 0, 0}, '{64, 255, 0, 0}, '{12, 1530, 0, 0}, 6);
`endif
  endtask

  task automatic test_zero();
    test_vectors("zero", 1'b0, 2, '{97, 0, 0, 0}, '{0, 255, 0, 0}, '{0, 0, 0, 0}, 6);
  endtask

  task automatic test_start_busy();
    int dcnt = 0;
    int res = -1;
    @(negedge clk);
    a_i = 8'd5; b_i = 8'd27; mode_i = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a_i = 8'd200; b_i = 8'd255; mode_i = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 50 && !done; k++) @(negedge clk);
    if (done) res = int'(result);
    total++; if (res !== 15) begin bad++; $display("FAIL midstart_result got=%0d want=15", res); end
    repeat (12) begin @(negedge clk); if (done) dcnt++; end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL midstart_extra_done got=%0d want=0", dcnt); end
  endtask

  task automatic test_reset_mid();
    int res, bcyc, dcnt;
    @(negedge clk);
    a_i = 8'd255; b_i = 8'd200; mode_i = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
    total++; if (result !== 12'd0) begin bad++; $display("FAIL rstmid_result got=%0d want=0", result); end
    @(negedge clk); rst = 1'b1;
    run_op(8'd9, 8'd125, 1'b0, res, bcyc, dcnt);
    total++; if (res !== 45) begin bad++; $display("FAIL rstmid_after got=%0d want=45", res); end
    total++; if (bcyc !== 6) begin bad++; $display("FAIL rstmid_busy_cycles got=%0d want=6", bcyc); end
  endtask

  task automatic test_back_to_back();
    int bcyc = 0;
    int res = -1;
    @(negedge clk);
    a_i = 8'd5; b_i = 8'd27; mode_i = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 50 && !done; k++) @(negedge clk);
    if (done) res = int'(result);
    total++; if (res !== 15) begin bad++; $display("FAIL b2b_first got=%0d want=15", res); end
    a_i = 8'd44; b_i = 8'd255;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_width got=%b want=0", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accepted got=%b want=1", busy); end
    start = 1'b0;
    res = -1;
    for (int k = 0; k < 50 && res < 0; k++) begin
      if (busy) bcyc++;
      if (done) res = int'(result);
      else @(negedge clk);
    end
    total++; if (res !== 264) begin bad++; $display("FAIL b2b_second got=%0d want=264", res); end
    total++; if (bcyc !== 6) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=6", bcyc); end
  endtask

  task automatic test_sweep();
    int res, bcyc, dcnt, a, b, exp, lat;
    bit m;
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255); m = 1'($urandom_range(0, 1));
      exp = a * ref_root(b, m);
      lat = eff_mode(m) ? 8 : 6;
      run_op(8'(a), 8'(b), m, res, bcyc, dcnt);
      total++; if (res !== exp) begin bad++; $display("FAIL sweep8 a=%0d b=%0d m=%0d got=%0d want=%0d", a, b, m, res, exp); end
      total++; if (bcyc !== lat) begin bad++; $display("FAIL sweep8_lat got=%0d want=%0d", bcyc, lat); end
    end
  endtask

  task automatic test_sweep12();
    int res, bcyc, dcnt, a, b, exp, lat;
    bit m;
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 4095); b = (i == 0) ? 4095 : $urandom_range(0, 4095); m = 1'($urandom_range(0, 1));
      if (i == 0) a = 4095;
      exp = a * ref_root(b, m);
      lat = eff_mode(m) ? 12 : 8;
      run_op12(12'(a), 12'(b), m, res, bcyc, dcnt);
      total++; if (res !== exp) begin bad++; $display("FAIL sweep12 a=%0d b=%0d m=%0d got=%0d want=%0d", a, b, m, res, exp); end
      total++; if (bcyc !== lat) begin bad++; $display("FAIL sweep12_lat got=%0d want=%0d", bcyc, lat); end
      total++; if (dcnt !== 1) begin bad++; $display("FAIL sweep12_done got=%0d want=1", dcnt); end
    end
  endtask

  initial begin
    test_reset();
    test_cbrt();
    test_sqrt();
    test_zero();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    test_sweep12();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fun_root_mul.md
# fun_root_mul

Sequential arithmetic unit that computes `result = a * floor(root(b))` for unsigned W-bit operands. In cube-root mode the root is the integer cube root; in square-root mode it is the integer square root. It is the parametrised successor of the fixed 8-bit `a * cbrt(b)` unit and keeps the same start/busy handshake. It sits as a multi-cycle datapath slave behind a controller that pulses `start` and polls `busy` or `done`.

## Interface
- `W`, default 8: operand width. Legal range is 4..32.
- `RES_W`, localparam: result width, equal to `W + (W+1)/2`. For W=8 this is 12, sized for the square-root worst case.
- `clk` input, 1 bit: the only clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request pulse. Sampled on a rising edge only while idle.
- `mode_i` input, 1 bit: 0 selects cube root, 1 selects square root. Latched together with the operands.
- `a_i` input, W bits: multiplicand.
- `b_i` input, W bits: radicand.
- `result` output, RES_W bits: product of `a` and the root. Holds its value between operations.
- `busy` output, 1 bit: high while an operation is in progress.
- `done` output, 1 bit: one-cycle pulse in the first cycle the new `result` is valid.

## Operation
- **Digit count N:**
  - Cube-root mode: N = ceil(W/3), giving 3 for W=8.
  - Square-root mode: N = ceil(W/2), giving 4 for W=8.
  - The root is always N bits wide.
- **States:** IDLE, ROOT, MUL.
- **IDLE:**
  - When `start`=1 on an edge, latch `a_i`, `b_i` and `mode_i`.
  - Clear the internal root, remainder and accumulator.
  - Go to ROOT and set `busy`=1.
- **ROOT** (N cycles): restoring digit recurrence, producing one root bit per cycle, MSB first.
  - Cube-root step: y=2y; t=3y(y+1)+1; if (rem>>s) >= t then rem -= t<<s and y++. The shift s steps down by 3 from 3(N-1).
  - Square-root step: y=2y; t=2y+1; same compare-subtract, with s stepping down by 2 from 2(N-1).
  - Intermediates are sized to avoid overflow at W=32.
- **MUL** (N cycles): shift-add multiply, LSB first.
  - In cycle i, acc += a<<i when root[i]=1.
  - On the last MUL edge: `result` <= final acc, `busy` <= 0, `done` <= 1, then return to IDLE.
- **`start` while busy:** ignored. It is neither queued nor does it restart the operation.
- **Operand/mode changes while busy:** no effect on the current operation.
- **Zero operands:** b=0 or a=0 gives `result`=0 with the normal latency. There is no early exit.
- **Range:** at maximum operands the product never exceeds RES_W bits. No saturation logic is present.
- **Reset** (asserted at any time, including mid-operation):
  - Immediately sets state=IDLE, `busy`=0, `done`=0, `result`=0, and clears all internal registers.
  - Any operation in flight is lost.

## Timing
- **Reset values:** `result`=0, `busy`=0, `done`=0.
- **Start accepted at edge E0:**
  - `busy` is high from after E0 through edge E0+2N, for 2N cycles in total.
  - At edge E0+2N, `busy` falls and `done` rises together with the new `result`.
- **Latency at W=8:** 6 cycles in cube-root mode, 8 cycles in square-root mode.
- **Back-to-back:** a `start` sampled on the same edge where `done` is high is accepted, because the state is already IDLE. Throughput is therefore one operation per 2N+1 cycles.
- **`done` duration:** exactly one cycle, even if `start` is held high.

## Configuration
- **`FUN_SQRT_EN` defined:**
  - The square-root path is built.
  - `mode_i` behaves as described above.
- **`FUN_SQRT_EN` undefined:**
  - Only the cube-root path is built.
  - `mode_i` is ignored and treated as 0.
  - N = ceil(W/3) always.
  - Port list and RES_W are unchanged.

## Structure
- **Package `fun_pkg`:**
  - Mode encodings `MODE_CBRT`=0 and `MODE_SQRT`=1.
  - State enum (IDLE/ROOT/MUL).
  - Constant functions `root_digits(W, mode)` and `res_width(W)`.
- **Sub-module `fun_root`:**
  - The digit-recurrence root unit: init, step and root output.
  - Parametrised by W.
  - The top level owns the FSM and the shift-add multiplier.

## Test plan
- **Cube-root mode, W=8, after reset:**
  - a=5, b=27 -> result=15; `busy` high exactly 6 cycles; `done` pulses once.
  - a=255, b=200 -> 1275.
  - a=44, b=255 -> 264.
- **Square-root mode, W=8:**
  - a=3, b=64 -> 24 in 8 cycles.
  - a=255, b=255 -> 3825.
- **Zero operands:**
  - a=97, b=0 -> 0.
  - a=0, b=255 -> 0.
  - In both cases `busy` still lasts 2N cycles.
- **`start` mid-operation:** a second `start` pulse in cycle 3 with different operands -> first result 15 unaffected; no second `done`.
- **Reset mid-operation:** pull `rst` low in cycle 2 -> `busy`, `done` and `result` become 0 immediately. A new a=9, b=125 operation after release -> 45.
- **Sweep (W=8 and W=12):** random a, b, mode against a reference model. Check back-to-back `start` on the `done` cycle. With `FUN_SQRT_EN` undefined, mode_i=1 still yields cube-root results.
